// File: rtl/uart_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_pkg
// Description : Shared types and constants for the UART program loader:
//               sequencer state encoding and op_uart CSR addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_prog_pkg;

    // Sequencer state encoding
    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_cfg     = 3'd1;
    localparam state_t c_st_arb     = 3'd2;
    localparam state_t c_st_fetch   = 3'd3;
    localparam state_t c_st_load    = 3'd4;
    localparam state_t c_st_write   = 3'd5;
    localparam state_t c_st_wait_tx = 3'd6;
    localparam state_t c_st_abort   = 3'd7;

    // op_uart CSR map
    localparam logic [13:0] CSR_DATA_ADDR = 14'h000;
    localparam logic [13:0] CSR_THRU_ADDR = 14'h002;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Two-requester alternating-priority grant for the shared UART
//               TX. When both request, the one that did not go last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb (
    input  logic i_cmd_last,
    input  logic i_req_stream,
    input  logic i_req_cmd,
    output logic o_grant_stream,
    output logic o_grant_cmd
);

    // Lone requester always wins; on contention the last winner yields
    assign o_grant_cmd    = i_req_cmd    & (~i_req_stream | ~i_cmd_last);
    assign o_grant_stream = i_req_stream & (~i_req_cmd    |  i_cmd_last);

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Streams a program image from byte memory into op_uart through
//               its CSR bus, one byte per tx_irq completion, and shares the TX
//               with a command-byte requester.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int   MEM_AW     = 12,
    parameter int   TX_TIMEOUT = 200000,
    parameter logic THRU_VAL   = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [MEM_AW:0]   length,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_data,
    output logic              cmd_ready,
    output logic [13:0]       csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_di,
    input  logic              tx_irq,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [MEM_AW:0]   sent_count
);

    localparam int                c_to_w    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TX_TIMEOUT - 1);
    localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);
    localparam logic [MEM_AW:0]   c_idx_one = {{MEM_AW{1'b0}}, 1'b1};

    state_t              r_state,    w_state_d;
    logic [MEM_AW:0]     r_len,      w_len_d;
    logic [MEM_AW:0]     r_idx,      w_idx_d;
    logic [MEM_AW:0]     r_sent,     w_sent_d;
    logic                r_busy,     w_busy_d;
    logic                r_done,     w_done_d;
    logic                r_timeout,  w_timeout_d;
    logic                r_cmd_last, w_cmd_last_d;
    logic                r_is_cmd,   w_is_cmd_d;
    logic [7:0]          r_byte,     w_byte_d;
    logic [c_to_w-1:0]   r_to_cnt,   w_to_cnt_d;
    logic                r_tx_irq_q;

    logic w_tx_rise;
    logic w_req_stream;
    logic w_grant_stream;
    logic w_grant_cmd;

    assign w_tx_rise    = tx_irq & ~r_tx_irq_q;
    assign w_req_stream = r_busy & (r_idx < r_len);

    uart_tx_arb u_arb (
        .i_cmd_last     (r_cmd_last),
        .i_req_stream   (w_req_stream),
        .i_req_cmd      (cmd_valid),
        .o_grant_stream (w_grant_stream),
        .o_grant_cmd    (w_grant_cmd)
    );

    // Sequencer registers, tx_irq edge register and timeout counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= c_st_idle;
            r_len      <= '0;
            r_idx      <= '0;
            r_sent     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cmd_last <= 1'b0;
            r_is_cmd   <= 1'b0;
            r_byte     <= '0;
            r_to_cnt   <= '0;
            r_tx_irq_q <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_len      <= w_len_d;
            r_idx      <= w_idx_d;
            r_sent     <= w_sent_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_timeout  <= w_timeout_d;
            r_cmd_last <= w_cmd_last_d;
            r_is_cmd   <= w_is_cmd_d;
            r_byte     <= w_byte_d;
            r_to_cnt   <= w_to_cnt_d;
            r_tx_irq_q <= tx_irq;
        end
    end

    // Next-state logic: transfer setup, arbitration, byte delivery, timeout
    always_comb begin
        w_state_d    = r_state;
        w_len_d      = r_len;
        w_idx_d      = r_idx;
        w_sent_d     = r_sent;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_timeout_d  = r_timeout;
        w_cmd_last_d = r_cmd_last;
        w_is_cmd_d   = r_is_cmd;
        w_byte_d     = r_byte;
        w_to_cnt_d   = r_to_cnt;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_timeout_d = 1'b0;
                    w_sent_d    = '0;
                    if (length != '0) begin
                        w_state_d = c_st_cfg;
                        w_len_d   = length;
                        w_idx_d   = '0;
                        w_busy_d  = 1'b1;
                    end else begin
                        w_done_d  = 1'b1;
                    end
                end else if (cmd_valid) begin
                    w_state_d = c_st_arb;
                end
            end
            c_st_cfg: w_state_d = c_st_arb;
            c_st_arb: begin
                if (w_grant_stream) begin
                    w_state_d    = c_st_fetch;
                    w_cmd_last_d = 1'b0;
                    w_is_cmd_d   = 1'b0;
                end else if (w_grant_cmd) begin
                    w_state_d    = c_st_write;
                    w_cmd_last_d = 1'b1;
                    w_is_cmd_d   = 1'b1;
                    w_byte_d     = cmd_data;
                end else begin
                    // Nothing left to send: close out an image transfer if one is open
                    w_state_d = c_st_idle;
                    w_done_d  = r_busy;
                    w_busy_d  = 1'b0;
                end
            end
            c_st_fetch: w_state_d = c_st_load;
            c_st_load: begin
                w_byte_d  = mem_data;
                w_state_d = c_st_write;
            end
            c_st_write: begin
                w_to_cnt_d = '0;
                w_state_d  = c_st_wait_tx;
            end
            c_st_wait_tx: begin
                if (w_tx_rise) begin
                    w_state_d = c_st_arb;
                    if (!r_is_cmd) begin
                        w_idx_d  = r_idx + c_idx_one;
                        w_sent_d = r_sent + c_idx_one;
                    end
                end else if (r_to_cnt == c_to_last) begin
                    w_state_d   = c_st_abort;
                    w_timeout_d = 1'b1;
                    w_busy_d    = 1'b0;
                end else begin
                    w_to_cnt_d = r_to_cnt + c_to_one;
                end
            end
            c_st_abort: w_state_d = c_st_idle;
            default:    w_state_d = c_st_idle;
        endcase
    end

    // State-decoded bus outputs; everything idles at zero
    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = '0;
        csr_we    = 1'b0;
        csr_a     = '0;
        csr_di    = '0;
        cmd_ready = 1'b0;
        case (r_state)
            c_st_cfg: begin
                csr_we = 1'b1;
                csr_a  = CSR_THRU_ADDR;
                csr_di = {31'b0, THRU_VAL};
            end
            c_st_fetch: begin
                mem_rd   = 1'b1;
                mem_addr = r_idx[MEM_AW-1:0];
            end
            c_st_write: begin
                csr_we    = 1'b1;
                csr_a     = CSR_DATA_ADDR;
                csr_di    = {24'h0, r_byte};
                cmd_ready = r_is_cmd;
            end
            default: ;
        endcase
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign sent_count = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_prog_loader
// Description : Directed self-checking bench for uart_prog_loader with a byte
//               memory model and a tx_irq responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int MEM_AW     = 12;
    localparam int TX_TIMEOUT = 100;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              start;
    logic [MEM_AW:0]   length;
    logic              mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_data = 8'h00;
    logic              cmd_valid;
    logic [7:0]        cmd_data;
    logic              cmd_ready;
    logic [13:0]       csr_a;
    logic              csr_we;
    logic [31:0]       csr_di;
    logic              tx_irq = 1'b0;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [MEM_AW:0]   sent_count;

    always #5 sys_clk = ~sys_clk;

    uart_prog_loader #(
        .MEM_AW     (MEM_AW),
        .TX_TIMEOUT (TX_TIMEOUT),
        .THRU_VAL   (1'b0)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .length     (length),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .csr_a      (csr_a),
        .csr_we     (csr_we),
        .csr_di     (csr_di),
        .tx_irq     (tx_irq),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .sent_count (sent_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte memory: data valid in the cycle after mem_rd
    logic [7:0] mem [0:4095];
    always @(negedge sys_clk) if (mem_rd) mem_data = mem[mem_addr];

    // UART model: tx_irq rises ~50 cycles after each data-register write
    int resp_cnt = 0;
    bit resp_en  = 1'b1;
    always @(negedge sys_clk) begin
        if (sys_rst) resp_cnt = 0;
        else if (resp_en && csr_we && csr_a == 14'h000) resp_cnt = 52;
        else if (resp_cnt > 0) resp_cnt--;
        tx_irq = (resp_cnt == 2) || (resp_cnt == 1);
    end

    // Activity log sampled mid-cycle
    int           cyc = 0;
    logic [13:0]  wa_q [$];
    logic [31:0]  wd_q [$];
    int           wc_q [$];
    logic [11:0]  rd_q [$];
    int           n_done = 0, n_cr = 0, cr_bad = 0, done_busy_bad = 0;
    bit           busy_seen = 1'b0;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (csr_we) begin
                wa_q.push_back(csr_a);
                wd_q.push_back(csr_di);
                wc_q.push_back(cyc);
            end
            if (mem_rd) rd_q.push_back(mem_addr);
            if (done) begin
                n_done++;
                if (busy) done_busy_bad++;
            end
            if (cmd_ready) begin
                n_cr++;
                if (!(csr_we && csr_a == 14'h000 && csr_di == {24'h0, cmd_data})) cr_bad++;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); rd_q.delete();
        n_done = 0; n_cr = 0; cr_bad = 0; done_busy_bad = 0; busy_seen = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start(input logic [MEM_AW:0] len, output int s);
        @(negedge sys_clk);
        start  = 1'b1;
        length = len;
        s      = cyc;
        @(negedge sys_clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n0 = n_done;
        int k  = 0;
        while (n_done == n0 && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check({tag, "_done_seen"}, 64'(n_done != n0), 64'd1);
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k = 0;
        while (wa_q.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check({tag, "_writes_seen"}, 64'(wa_q.size() >= n), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, w, k;
        logic [55:0] pk;
        logic [47:0] ra;
        logic [13:0] aor;

        sys_rst = 1'b1; start = 1'b0; length = '0; cmd_valid = 1'b0; cmd_data = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i ^ 32'h5A);
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;

        // Reset state
        tick(3);
        check("rst_ctrl", 64'({busy, done, timeout, csr_we, mem_rd, cmd_ready}), 64'd0);
        check("rst_bus",  64'({csr_a, csr_di}), 64'd0);
        check("rst_cnt",  64'({mem_addr, sent_count}), 64'd0);
        sys_rst = 1'b0;
        tick(2);
        clear_logs();

        // Basic 4-byte image
        pulse_start(13'd4, s);
        wait_done(1000, "t1");
        check("t1_nwr", 64'(wa_q.size()), 64'd5);
        check("t1_thru", {18'h0, wa_q[0], wd_q[0]}, {18'h0, 14'h002, 32'h0});
        pk = '0; aor = '0;
        for (int i = 1; i < 5; i++) begin
            pk  = {pk[47:0], wd_q[i][7:0]};
            aor = aor | wa_q[i];
        end
        check("t1_data", 64'(pk), 64'hA1B2C3D4);
        check("t1_addr", 64'(aor), 64'd0);
        check("t1_lat_thru", 64'(wc_q[0] - s), 64'd1);
        check("t1_lat_data", 64'(wc_q[1] - s), 64'd5);
        ra = {rd_q[0], rd_q[1], rd_q[2], rd_q[3]};
        check("t1_rdaddr", 64'(ra), {16'h0, 12'd0, 12'd1, 12'd2, 12'd3});
        tick(3);
        check("t1_ndone", 64'(n_done), 64'd1);
        check("t1_done_busy", 64'(done_busy_bad), 64'd0);
        check("t1_sent", 64'(sent_count), 64'd4);
        check("t1_ncr", 64'(n_cr), 64'd0);
        clear_logs();

        // Command byte interleaved with the stream
        pulse_start(13'd4, s);
        wait_writes(2, 200, "t2");
        cmd_data  = 8'h67;
        cmd_valid = 1'b1;
        k = 0;
        while (n_cr < 3 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        check("t2_cr_seen", 64'(n_cr >= 3), 64'd1);
        cmd_valid = 1'b0;
        wait_done(1000, "t2");
        tick(3);
        check("t2_nwr", 64'(wa_q.size()), 64'd8);
        pk = '0;
        for (int i = 1; i < 8; i++) pk = {pk[47:0], wd_q[i][7:0]};
        check("t2_order", 64'(pk), 64'h00A167B267C367D4);
        check("t2_ncr", 64'(n_cr), 64'd3);
        check("t2_cr_align", 64'(cr_bad), 64'd0);
        check("t2_ndone", 64'(n_done), 64'd1);
        check("t2_sent", 64'(sent_count), 64'd4);
        clear_logs();

        // Command-only service while idle
        cmd_data  = 8'h54;
        cmd_valid = 1'b1;
        k = 0;
        while (n_cr < 1 && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        cmd_valid = 1'b0;
        tick(80);
        check("t3_nwr", 64'(wa_q.size()), 64'd1);
        check("t3_wr", {18'h0, wa_q[0], wd_q[0]}, {18'h0, 14'h000, 32'h54});
        check("t3_ncr", 64'(n_cr), 64'd1);
        check("t3_busy", 64'(busy_seen), 64'd0);
        check("t3_ndone", 64'(n_done), 64'd0);
        check("t3_sent", 64'(sent_count), 64'd4);
        clear_logs();

        // Zero-length image
        pulse_start(13'd0, s);
        check("t4_done_now", 64'(done), 64'd1);
        tick(10);
        check("t4_nwr", 64'(wa_q.size()), 64'd0);
        check("t4_ndone", 64'(n_done), 64'd1);
        check("t4_busy", 64'(busy_seen), 64'd0);
        check("t4_sent", 64'(sent_count), 64'd0);
        clear_logs();

        // TX timeout
        resp_en = 1'b0;
        pulse_start(13'd4, s);
        wait_writes(2, 50, "t5");
        w = wc_q[1];
        k = 0;
        while (cyc < w + 99 && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("t5_to_early", 64'(timeout), 64'd0);
        tick(3);
        check("t5_to_set", 64'({timeout, busy}), 64'b10);
        tick(5);
        check("t5_ndone", 64'(n_done), 64'd0);
        check("t5_nwr", 64'(wa_q.size()), 64'd2);
        check("t5_sent", 64'(sent_count), 64'd0);
        resp_en = 1'b1;
        clear_logs();
        pulse_start(13'd4, s);
        check("t5_to_clear", 64'({timeout, busy}), 64'b01);
        wait_done(1000, "t5b");
        tick(3);
        check("t5b_state", 64'({timeout, sent_count}), 64'd4);
        clear_logs();

        // Reset in the middle of a 4096-byte image
        pulse_start(13'h1000, s);
        k = 0;
        while (sent_count != 13'd2 && k < 500) begin
            @(negedge sys_clk);
            k++;
        end
        check("t6_reached2", 64'(sent_count), 64'd2);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_rst_ctrl", 64'({busy, done, timeout, csr_we, mem_rd, cmd_ready}), 64'd0);
        check("t6_rst_bus",  64'({csr_a, csr_di}), 64'd0);
        check("t6_rst_cnt",  64'({mem_addr, sent_count}), 64'd0);
        sys_rst = 1'b0;
        tick(2);
        clear_logs();
        pulse_start(13'd4, s);
        wait_done(1000, "t6");
        tick(3);
        check("t6_thru_first", {18'h0, wa_q[0], wd_q[0]}, {18'h0, 14'h002, 32'h0});
        check("t6_rd0", 64'(rd_q[0]), 64'd0);
        check("t6_byte0", 64'(wd_q[1]), 64'hA1);
        check("t6_sent", 64'(sent_count), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
